// File: rtl/sprite_motion_ctrl_if.sv
// Host configuration channel for sprite_motion_ctrl: valid/ready handshake carrying
// a new position and velocity.
interface sprite_motion_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [9:0] cfg_x;
    logic [9:0] cfg_y;
    logic [3:0] cfg_dx;
    logic [3:0] cfg_dy;

    modport master (
        output cfg_valid, cfg_x, cfg_y, cfg_dx, cfg_dy,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_x, cfg_y, cfg_dx, cfg_dy,
        output cfg_ready
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite motion scheduler: steps X then Y, commits both on one edge.
// Define SPRITE_BOUNCE_EN for bounce at the edges; default build wraps around.
module sprite_motion_ctrl #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned SPRITE_W  = 160,
    parameter int unsigned SPRITE_H  = 160,
    parameter int unsigned FRAME_DIV = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_frame_start,
    sprite_motion_ctrl_if.slave        cfg,
    output logic [9:0]                 o_spr_x,
    output logic [9:0]                 o_spr_y,
    output logic                       o_update_done,
    output logic                       o_busy
);

    localparam logic [9:0] X_MAX   = 10'(H_DISPLAY - SPRITE_W);
    localparam logic [9:0] Y_MAX   = 10'(V_DISPLAY - SPRITE_H);
    localparam logic [3:0] FC_LAST = 4'(FRAME_DIV - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STEP_X = 2'd1;
    localparam logic [1:0] ST_STEP_Y = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]        r_state;
    logic [3:0]        r_fc;
    logic [9:0]        r_wx, r_wy, r_spr_x, r_spr_y;
    logic signed [3:0] r_vx, r_vy;
    logic              r_update_done;

    logic              w_idle, w_hs, w_step_y;
    logic [9:0]        w_pos, w_max, w_new_pos, w_cfg_x, w_cfg_y;
    logic signed [3:0] w_vel, w_new_vel;
    logic signed [10:0] w_sum, w_max_s;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_hs          = cfg.cfg_valid && w_idle;
    assign cfg.cfg_ready = w_idle;
    assign o_busy        = !w_idle;
    assign o_spr_x       = r_spr_x;
    assign o_spr_y       = r_spr_y;
    assign o_update_done = r_update_done;

    assign w_cfg_x = (cfg.cfg_x > X_MAX) ? X_MAX : cfg.cfg_x;
    assign w_cfg_y = (cfg.cfg_y > Y_MAX) ? Y_MAX : cfg.cfg_y;

    // One adder serves both axes; STEP_X and STEP_Y are never active together.
    assign w_step_y = (r_state == ST_STEP_Y);
    assign w_pos    = w_step_y ? r_wy : r_wx;
    assign w_vel    = w_step_y ? r_vy : r_vx;
    assign w_max    = w_step_y ? Y_MAX : X_MAX;
    assign w_max_s  = $signed({1'b0, w_max});
    assign w_sum    = $signed({1'b0, w_pos}) + $signed({{7{w_vel[3]}}, w_vel});

`ifdef SPRITE_BOUNCE_EN
    logic signed [3:0] w_vel_neg;
    // -(-8) does not fit in 4 bits, so it saturates to +7
    assign w_vel_neg = (w_vel == 4'sb1000) ? 4'sd7 : -w_vel;
`endif

    always_comb begin
        w_new_pos = w_sum[9:0];
        w_new_vel = w_vel;
        if (w_sum < 11'sd0) begin
`ifdef SPRITE_BOUNCE_EN
            w_new_pos = '0;
            w_new_vel = w_vel_neg;
`else
            w_new_pos = 10'(w_sum + w_max_s + 11'sd1);
`endif
        end else if (w_sum > w_max_s) begin
`ifdef SPRITE_BOUNCE_EN
            w_new_pos = w_max;
            w_new_vel = w_vel_neg;
`else
            w_new_pos = 10'(w_sum - w_max_s - 11'sd1);
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_fc          <= '0;
            r_wx          <= 10'd240;
            r_wy          <= 10'd160;
            r_spr_x       <= 10'd240;
            r_spr_y       <= 10'd160;
            r_vx          <= 4'sd1;
            r_vy          <= 4'sd1;
            r_update_done <= 1'b0;
        end else begin
            r_update_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Configuration wins over a coincident frame pulse
                    if (w_hs) begin
                        r_wx    <= w_cfg_x;
                        r_spr_x <= w_cfg_x;
                        r_wy    <= w_cfg_y;
                        r_spr_y <= w_cfg_y;
                        r_vx    <= $signed(cfg.cfg_dx);
                        r_vy    <= $signed(cfg.cfg_dy);
                        r_fc    <= '0;
                    end else if (i_frame_start) begin
                        if (r_fc == FC_LAST) begin
                            r_fc    <= '0;
                            r_state <= ST_STEP_X;
                        end else begin
                            r_fc <= r_fc + 4'd1;
                        end
                    end
                end
                ST_STEP_X: begin
                    r_wx    <= w_new_pos;
                    r_vx    <= w_new_vel;
                    r_state <= ST_STEP_Y;
                end
                ST_STEP_Y: begin
                    r_wy    <= w_new_pos;
                    r_vy    <= w_new_vel;
                    r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_spr_x       <= r_wx;
                    r_spr_y       <= r_wy;
                    r_update_done <= 1'b1;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed + randomized bench for sprite_motion_ctrl against an integer reference model.
module tb_sprite_motion_ctrl;

    logic       clk;
    logic       rst_n;
    logic       fs1, fs3;
    logic [9:0] sx1, sy1, sx3, sy3;
    logic       ud1, busy1, ud3, busy3;
    int         checks   = 0;
    int         failures = 0;
    int         ud1_cnt  = 0;
    int         ud3_cnt  = 0;

    // Reference model state for the FRAME_DIV=1 instance
    int m_x, m_y, m_vx, m_vy;

    sprite_motion_ctrl_if cfg1 ();
    sprite_motion_ctrl_if cfg3 ();

    sprite_motion_ctrl u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (fs1),
        .cfg           (cfg1),
        .o_spr_x       (sx1),
        .o_spr_y       (sy1),
        .o_update_done (ud1),
        .o_busy        (busy1)
    );

    sprite_motion_ctrl #(.FRAME_DIV(3)) u_dut3 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (fs3),
        .cfg           (cfg3),
        .o_spr_x       (sx3),
        .o_spr_y       (sy3),
        .o_update_done (ud3),
        .o_busy        (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ud1 === 1'b1) ud1_cnt++;
        if (ud3 === 1'b1) ud3_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = 240; m_y = 160; m_vx = 1; m_vy = 1;
    endtask

    task automatic model_axis(inout int pos, inout int vel, input int mx);
        int n;
        n = pos + vel;
        if (n < 0) begin
`ifdef SPRITE_BOUNCE_EN
            pos = 0;
            vel = (vel == -8) ? 7 : -vel;
`else
            pos = n + mx + 1;
`endif
        end else if (n > mx) begin
`ifdef SPRITE_BOUNCE_EN
            pos = mx;
            vel = (vel == -8) ? 7 : -vel;
`else
            pos = n - (mx + 1);
`endif
        end else begin
            pos = n;
        end
    endtask

    // Handshake on DUT1; the new position must be visible right after the edge.
    task automatic configure(input int x, input int y, input logic [3:0] dx, input logic [3:0] dy);
        int c0;
        c0 = ud1_cnt;
        cfg1.cfg_valid = 1'b1;
        cfg1.cfg_x = 10'(x); cfg1.cfg_y = 10'(y);
        cfg1.cfg_dx = dx;    cfg1.cfg_dy = dy;
        tick();
        cfg1.cfg_valid = 1'b0;
        m_x = (x > 480) ? 480 : x;
        m_y = (y > 320) ? 320 : y;
        m_vx = $signed(dx);
        m_vy = $signed(dy);
        check("cfg_spr_x", 32'(sx1), 32'(m_x));
        check("cfg_spr_y", 32'(sy1), 32'(m_y));
        check("cfg_no_done", 32'(ud1_cnt - c0), 32'd0);
    endtask

    // One FRAME_START on DUT1 with full edge-by-edge timing checks.
    task automatic do_step(input string tag);
        int ox, oy;
        ox = m_x; oy = m_y;
        fs1 = 1'b1;
        tick();
        fs1 = 1'b0;
        check({tag, "_busy_e0"}, 32'(busy1), 32'd1);
        check({tag, "_ready_e0"}, 32'(cfg1.cfg_ready), 32'd0);
        tick();
        tick();
        check({tag, "_busy_e2"}, 32'(busy1), 32'd1);
        check({tag, "_hold_x_e2"}, 32'(sx1), 32'(ox));
        check({tag, "_hold_y_e2"}, 32'(sy1), 32'(oy));
        check({tag, "_done_e2"}, 32'(ud1), 32'd0);
        model_axis(m_x, m_vx, 480);
        model_axis(m_y, m_vy, 320);
        tick();
        check({tag, "_x"}, 32'(sx1), 32'(m_x));
        check({tag, "_y"}, 32'(sy1), 32'(m_y));
        check({tag, "_done_e3"}, 32'(ud1), 32'd1);
        check({tag, "_busy_e3"}, 32'(busy1), 32'd0);
        tick();
        check({tag, "_done_e4"}, 32'(ud1), 32'd0);
    endtask

    task automatic pulse3();
        fs3 = 1'b1;
        tick();
        fs3 = 1'b0;
    endtask

    initial begin
        int c0, nsteps;
        fs1 = 1'b0; fs3 = 1'b0;
        cfg1.cfg_valid = 1'b0; cfg1.cfg_x = '0; cfg1.cfg_y = '0; cfg1.cfg_dx = '0; cfg1.cfg_dy = '0;
        cfg3.cfg_valid = 1'b0; cfg3.cfg_x = '0; cfg3.cfg_y = '0; cfg3.cfg_dx = '0; cfg3.cfg_dy = '0;
        model_reset();

        // Reset asserted mid-cycle
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_spr_x", 32'(sx1), 32'd240);
        check("rst_spr_y", 32'(sy1), 32'd160);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_ready", 32'(cfg1.cfg_ready), 32'd1);
        check("rst_done", 32'(ud1), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rel_spr_x", 32'(sx1), 32'd240);
        check("rel_busy", 32'(busy1), 32'd0);
        do_step("first");
        check("first_const_x", 32'(sx1), 32'd241);
        check("first_const_y", 32'(sy1), 32'd161);

        // Right edge
        configure(478, 100, 4'd3, 4'd0);
        do_step("right1");
`ifdef SPRITE_BOUNCE_EN
        check("right1_const", 32'(sx1), 32'd480);
`else
        check("right1_const", 32'(sx1), 32'd0);
`endif
        do_step("right2");
`ifdef SPRITE_BOUNCE_EN
        check("right2_const", 32'(sx1), 32'd477);
`else
        check("right2_const", 32'(sx1), 32'd3);
`endif

        // Negative edge on Y
        configure(10, 1, 4'd0, 4'hC);
        do_step("neg1");
`ifdef SPRITE_BOUNCE_EN
        check("neg1_const", 32'(sy1), 32'd0);
`else
        check("neg1_const", 32'(sy1), 32'd318);
`endif
        do_step("neg2");
`ifdef SPRITE_BOUNCE_EN
        check("neg2_const", 32'(sy1), 32'd4);
`else
        check("neg2_const", 32'(sy1), 32'd314);
`endif

        // Zero velocity still pulses UPDATE_DONE
        configure(50, 60, 4'd0, 4'd0);
        do_step("zero");

        // Clamping
        configure(1000, 1000, 4'h8, 4'h8);
        check("clamp_x_const", 32'(sx1), 32'd480);
        check("clamp_y_const", 32'(sy1), 32'd320);
        do_step("clamp_step");

        // Config and FRAME_START in the same cycle: config wins, no step
        c0 = ud1_cnt;
        cfg1.cfg_valid = 1'b1;
        cfg1.cfg_x = 10'd123; cfg1.cfg_y = 10'd45; cfg1.cfg_dx = 4'd2; cfg1.cfg_dy = 4'd2;
        fs1 = 1'b1;
        tick();
        cfg1.cfg_valid = 1'b0;
        fs1 = 1'b0;
        m_x = 123; m_y = 45; m_vx = 2; m_vy = 2;
        check("coll_busy", 32'(busy1), 32'd0);
        repeat (5) tick();
        check("coll_x", 32'(sx1), 32'd123);
        check("coll_y", 32'(sy1), 32'd45);
        check("coll_no_done", 32'(ud1_cnt - c0), 32'd0);
        do_step("coll_after");

        // Frame division on the FRAME_DIV=3 instance
        c0 = ud3_cnt;
        pulse3(); pulse3(); pulse3();
        check("div_busy", 32'(busy3), 32'd1);
        pulse3(); pulse3();
        repeat (4) tick();
        check("div_after3", 32'(ud3_cnt - c0), 32'd1);
        pulse3(); tick(); pulse3();
        repeat (6) tick();
        check("div_after5", 32'(ud3_cnt - c0), 32'd1);
        pulse3();
        repeat (6) tick();
        check("div_after6", 32'(ud3_cnt - c0), 32'd2);
        check("div_x", 32'(sx3), 32'd242);
        check("div_y", 32'(sy3), 32'd162);

        // Reset during STEP_Y discards the step
        c0 = ud1_cnt;
        fs1 = 1'b1;
        tick();
        fs1 = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_x", 32'(sx1), 32'd240);
        check("mid_rst_y", 32'(sy1), 32'd160);
        check("mid_rst_busy", 32'(busy1), 32'd0);
        check("mid_rst_done", 32'(ud1), 32'd0);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (5) tick();
        check("mid_rst_no_done", 32'(ud1_cnt - c0), 32'd0);
        do_step("post_rst");

        // Randomized configurations and steps
        for (int i = 0; i < 25; i++) begin
            configure(int'($urandom_range(0, 600)), int'($urandom_range(0, 450)),
                      4'($urandom), 4'($urandom));
            nsteps = int'($urandom_range(1, 4));
            for (int s = 0; s < nsteps; s++) begin
                repeat ($urandom_range(0, 3)) tick();
                do_step("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
